partition_sweep_ctrl: RTL and testbench
=======================================

PARTITION_SWEEP_CTRL -- requirements
Module: partition_sweep_ctrl

Interface
REQ-001 SHALL have parameter NI, default 7, partition input width.
REQ-002 SHALL have parameter NO, default 4, partition output width.
REQ-003 SHALL have parameter ERRW, default 10, width of hd_sum; NI+3 or more is required for NO=4.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port start, input, 1, sweep request, sampled in IDLE only.
REQ-007 SHALL have port hold, input, 1, pause; freezes RUN/DRAIN state.
REQ-008 SHALL have port pi, output, NI, registered pattern driven to both partition copies (exact and approximate).
REQ-009 SHALL have port po_exact, input, NO, exact partition response to pi.
REQ-010 SHALL have port po_approx, input, NO, approximate partition response to pi.
REQ-011 SHALL have port busy, output, 1, high in RUN and DRAIN.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port err_count, output, NI+1, number of patterns with po_exact != po_approx.
REQ-014 SHALL have port hd_sum, output, ERRW, sum over patterns of popcount(po_exact ^ po_approx).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 SHALL, in IDLE with start=1 at an edge: enter RUN, set pi=0, clear err_count, hd_sum and the capture-valid flag.
REQ-017 SHALL, at each RUN edge with hold=0: register po_exact/po_approx into capture registers with valid=1, and accumulate the previous capture if it is valid.
REQ-018 SHALL, at each RUN edge with hold=0, increment pi; at pi=2^NI-1 it wraps to 0 and the FSM enters DRAIN.
REQ-019 SHALL, in DRAIN with hold=0: accumulate the final capture, clear valid and enter DONE.
REQ-020 SHALL assert done for exactly the DONE cycle and then return to IDLE.
REQ-021 SHALL give latency start edge to done-high of exactly 2^NI+2 edges (130 for NI=7) with hold=0 throughout.
REQ-022 SHALL freeze, while hold=1 in RUN or DRAIN: pi, capture registers, valid, accumulators and state; no pattern is counted twice or skipped.
REQ-023 SHALL ignore hold in IDLE and DONE.
REQ-024 SHALL ignore start outside IDLE, including in the DONE cycle.
REQ-025 SHALL hold err_count and hd_sum stable from DONE until the next accepted start.
REQ-026 SHALL treat accumulators as unsigned and non-saturating; widths are sized for the all-mismatch worst case (err_count=2^NI, hd_sum=NO*2^NI).
REQ-027 SHALL make busy a pure decode of state; pi SHALL hold its last value (0) outside RUN.

Reset
REQ-028 SHALL, while rst=1 at an edge, force state=IDLE, pi=0, busy=0, done=0, err_count=0, hd_sum=0, valid=0 and capture registers=0, regardless of start or hold.
REQ-029 SHALL let rst mid-sweep abandon the sweep with no done pulse; the next start begins a full sweep from pattern 0.

Configuration
REQ-030 SHALL, when SWEEP_WCE_EN is defined, add output wce [NO-1:0]: maximum over patterns of |po_exact - po_approx| (unsigned magnitudes), updated at accumulate, cleared on start and reset, held like err_count.
REQ-031 SHALL, when SWEEP_WCE_EN is undefined, have no wce port and no difference or compare logic.

Verification
REQ-032 SHALL verify: po_approx tied to po_exact, start pulse -> done at edge 130, err_count=0, hd_sum=0, busy high for 129 cycles.
REQ-033 SHALL verify: po_approx = po_exact ^ 4'b0101 for all patterns -> err_count=128, hd_sum=256.
REQ-034 SHALL verify: mismatch 4'b1111 only at pi=127 -> err_count=1, hd_sum=4 (checks the DRAIN path).
REQ-035 SHALL verify: mismatch only at pi=0, with hold=1 for 5 cycles at pi=40 and 3 cycles in DRAIN -> err_count=1, hd_sum=1, done at edge 138.
REQ-036 SHALL verify: rst asserted at pi=50, then start -> no done pulse before the restart, outputs 0 after reset, full correct results after the restart, and a start during busy is ignored.
REQ-037 SHALL verify: with SWEEP_WCE_EN, po_exact=pi[3:0] and po_approx=0 -> wce=15, err_count=120.

Source files
------------

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive sweep of an NI-input partition, comparing exact vs approximate copies.
// Optional SWEEP_WCE_EN adds a worst-case |exact - approx| output (wce).
module partition_sweep_ctrl #(
  parameter int NI   = 7,
  parameter int NO   = 4,
  parameter int ERRW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  output logic [NI-1:0]   pi,
  input  logic [NO-1:0]   po_exact,
  input  logic [NO-1:0]   po_approx,
  output logic            busy,
  output logic            done,
  output logic [NI:0]     err_count,
`ifdef SWEEP_WCE_EN
  output logic [NO-1:0]   wce,
`endif
  output logic [ERRW-1:0] hd_sum
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [NO-1:0]   cap_e, cap_a;
  logic            vld;
  logic [NO-1:0]   diff;
  logic [ERRW-1:0] pc;
  logic            mism;
  logic            acc_en;

  assign busy = (state == RUN) || (state == DRAIN);

  // Scoring works on the capture registers, one cycle behind pi.
  always_comb begin
    diff = cap_e ^ cap_a;
    mism = |diff;
    pc   = '0;
    for (int i = 0; i < NO; i++) pc = pc + ERRW'(diff[i]);
  end

  assign acc_en = busy && !hold && vld;

`ifdef SWEEP_WCE_EN
  logic [NO-1:0] absd;
  assign absd = (cap_e >= cap_a) ? (cap_e - cap_a) : (cap_a - cap_e);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pi        <= '0;
      done      <= 1'b0;
      err_count <= '0;
      hd_sum    <= '0;
      vld       <= 1'b0;
      cap_e     <= '0;
      cap_a     <= '0;
`ifdef SWEEP_WCE_EN
      wce       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            pi        <= '0;
            err_count <= '0;
            hd_sum    <= '0;
            vld       <= 1'b0;
`ifdef SWEEP_WCE_EN
            wce       <= '0;
`endif
          end
        end
        RUN: if (!hold) begin
          cap_e <= po_exact;
          cap_a <= po_approx;
          vld   <= 1'b1;
          pi    <= pi + NI'(1);
          if (pi == {NI{1'b1}}) state <= DRAIN;
        end
        DRAIN: if (!hold) begin
          vld   <= 1'b0;
          state <= DONE;
          done  <= 1'b1;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase

      if (acc_en) begin
        err_count <= err_count + (NI+1)'(mism);
        hd_sum    <= hd_sum + pc;
`ifdef SWEEP_WCE_EN
        if (absd > wce) wce <= absd;
`endif
      end
    end
  end

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Randomized/directed bench for partition_sweep_ctrl against a whole-table reference model.
module tb_partition_sweep_ctrl;
  localparam int NI = 7, NO = 4, ERRW = 10, NP = 1 << NI;

  logic clk = 1'b0, rst, start, hold;
  logic [NI-1:0] pi;
  logic [NO-1:0] po_exact, po_approx;
  logic busy, done;
  logic [NI:0] err_count;
  logic [ERRW-1:0] hd_sum;
`ifdef SWEEP_WCE_EN
  logic [NO-1:0] wce;
`endif

  logic [NO-1:0] tbl_e [NP];
  logic [NO-1:0] tbl_a [NP];
  assign po_exact  = tbl_e[pi];
  assign po_approx = tbl_a[pi];

  always #5 clk = ~clk;

  partition_sweep_ctrl #(.NI(NI), .NO(NO), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .pi(pi),
    .po_exact(po_exact), .po_approx(po_approx), .busy(busy), .done(done),
    .err_count(err_count),
`ifdef SWEEP_WCE_EN
    .wce(wce),
`endif
    .hd_sum(hd_sum));

  int n_vec = 0, n_bad = 0;
  int exp_err, exp_hd, exp_wce;
  int lat, bcyc, hx;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Reference: score every pattern of the tables directly.
  task automatic ref_model();
    exp_err = 0; exp_hd = 0; exp_wce = 0;
    for (int p = 0; p < NP; p++) begin
      int d;
      if (tbl_e[p] != tbl_a[p]) exp_err++;
      exp_hd += $countones(tbl_e[p] ^ tbl_a[p]);
      d = int'(tbl_e[p]) - int'(tbl_a[p]);
      if (d < 0) d = -d;
      if (d > exp_wce) exp_wce = d;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // hmode: 0 no hold, 1 random hold, 2 hold 5 cycles at pi=40 and 3 in DRAIN.
  task automatic sweep(input int hmode, input bit mid_start);
    int h40 = 0, hdr = 0;
    bit fin = 0;
    hx = 0; bcyc = 0;
    start = 1'b1;
    hold  = (hmode == 1) ? 1'b1 : 1'b0;  // hold must be ignored in IDLE
    step();
    start = 1'b0;
    lat = 1;
    for (int k = 0; k < 600; k++) begin
      if (done) begin fin = 1; break; end
      if (busy) bcyc++;
      hold = 1'b0;
      if (hmode == 1) hold = ($urandom_range(0, 3) == 0);
      if (hmode == 2 && busy && pi == 7'd40 && h40 < 5) begin hold = 1'b1; h40++; end
      if (hmode == 2 && busy && pi == 7'd0 && lat > 2 && hdr < 3) begin hold = 1'b1; hdr++; end
      if (busy && hold) hx++;
      start = (mid_start && lat == 60);
      step();
      start = 1'b0;
      lat++;
    end
    hold = 1'b0;
    if (!fin) chk("timeout", 0, 1);
  endtask

  task automatic post_chk(input string nm);
    int e0, h0;
    chk({nm, ".lat"}, lat, NP + 2 + hx);
    chk({nm, ".busy_cyc"}, bcyc, NP + 1 + hx);
    chk({nm, ".err"}, int'(err_count), exp_err);
    chk({nm, ".hd"}, int'(hd_sum), exp_hd);
`ifdef SWEEP_WCE_EN
    chk({nm, ".wce"}, int'(wce), exp_wce);
`endif
    e0 = int'(err_count); h0 = int'(hd_sum);
    start = 1'b1;  // in the DONE cycle: must be ignored
    step();
    start = 1'b0;
    chk({nm, ".done_1cyc"}, int'(done), 0);
    chk({nm, ".idle"}, int'(busy), 0);
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    chk({nm, ".idle2"}, int'(busy), 0);
    chk({nm, ".err_hold"}, int'(err_count), e0);
    chk({nm, ".hd_hold"}, int'(hd_sum), h0);
    chk({nm, ".pi_rest"}, int'(pi), 0);
  endtask

  task automatic rand_tables(input int mis_pct);
    for (int p = 0; p < NP; p++) begin
      tbl_e[p] = NO'($urandom);
      tbl_a[p] = ($urandom_range(0, 99) < mis_pct) ? NO'($urandom) : tbl_e[p];
    end
  endtask

  initial begin
    bit seen;
    for (int p = 0; p < NP; p++) begin tbl_e[p] = '0; tbl_a[p] = '0; end
    rst = 1'b1; start = 1'b1; hold = 1'b1;
    repeat (3) step();
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.pi", int'(pi), 0);
    chk("rst.err", int'(err_count), 0);
    chk("rst.hd", int'(hd_sum), 0);
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    step();
    chk("rst.idle", int'(busy), 0);

    rand_tables(0);
    ref_model(); sweep(0, 0); post_chk("equal");

    for (int p = 0; p < NP; p++) tbl_a[p] = tbl_e[p] ^ 4'b0101;
    ref_model(); chk("xor.ref_err", exp_err, 128);
    sweep(0, 0); post_chk("xor");

    rand_tables(0); tbl_a[NP-1] = tbl_e[NP-1] ^ 4'b1111;
    ref_model(); sweep(0, 0); post_chk("last");

    rand_tables(0); tbl_a[0] = tbl_e[0] ^ 4'b0001;
    ref_model(); sweep(2, 0);
    chk("hold.extra", hx, 8);
    post_chk("hold");

    // Abort mid-sweep with reset.
    rand_tables(30);
    start = 1'b1; step(); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && !(busy && pi == 7'd50); k++) begin
      if (done) seen = 1;
      step();
    end
    chk("abort.reach50", int'(pi), 50);
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort.busy", int'(busy), 0);
    chk("abort.pi", int'(pi), 0);
    chk("abort.err", int'(err_count), 0);
    chk("abort.hd", int'(hd_sum), 0);
    for (int k = 0; k < 140; k++) begin
      if (done) seen = 1;
      step();
    end
    chk("abort.nodone", int'(seen), 0);
    ref_model(); sweep(0, 1); post_chk("restart");

    for (int t = 0; t < 6; t++) begin
      rand_tables($urandom_range(0, 100));
      ref_model(); sweep(1, t[0]); post_chk("rand");
    end

`ifdef SWEEP_WCE_EN
    for (int p = 0; p < NP; p++) begin
      logic [NI-1:0] pv;
      pv = NI'(p);
      tbl_e[p] = pv[3:0]; tbl_a[p] = '0;
    end
    ref_model(); chk("wce.ref", exp_wce, 15);
    sweep(0, 0); post_chk("wce");
    chk("wce.err120", int'(err_count), 120);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
